serial_fs_approx: RTL and testbench
===================================

// Module: serial_fs_approx
// PURPOSE
//  Bit-serial subtractor built from one full-subtractor cell and a borrow flop; the
//  subtract-side counterpart of the approximate full-adder cell used in the filter datapath.
//  Computes D = A - B - BIN over WIDTH bits, LSB first, one bit per clock.
//  Low APPROX_LSBS bits use a selectable approximate cell; upper bits are exact.
//  Valid/ready on both sides; used for area-reduced difference stages in the HPF.
// PARAMETERS
//  WIDTH        8  operand/result width in bits (>=2)
//  APPROX_LSBS  0  number of LSB positions using the approximate cell (0..WIDTH)
//  APPROX_MODE  0  cell for approx bits: 0 exact, 1 AFS1, 2 AFS2, 3 AFS3 (see BEHAVIOUR)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand word valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  diff       out  WIDTH  difference
//  bout       out  1      borrow-out from MSB position
// BEHAVIOUR
//  Reset (sync): state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, counter=0, borrow=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready edge: latch a,b into shift regs, borrow<=bin,
//         cnt<=0, go RUN. in_valid while not ready is ignored (no latching).
//   RUN:  in_ready=0. Each edge: cell on (a_sr[0], b_sr[0], borrow); shift d bit in at
//         result MSB, shift a_sr/b_sr right, borrow<=bo, cnt++. After edge with
//         cnt==WIDTH-1: diff<=result, bout<=bo, go DONE.
//   DONE: out_valid=1, in_ready=0; diff/bout held stable. On out_valid&out_ready edge ->
//         IDLE (out_valid=0 next cycle). No new accept in DONE.
//  Latency: out_valid first high WIDTH cycles after accept edge; throughput one op per
//   WIDTH+2 cycles minimum (accept, WIDTH run edges, handshake).
//  Cell at bit i (i<APPROX_LSBS uses APPROX_MODE, else mode 0); x=a,y=b,c=borrow:
//   mode0 exact: d=x^y^c;            bo=(~x&y)|(~(x^y)&c)
//   mode1 AFS1 : d=x^y;              bo=exact
//   mode2 AFS2 : d=(x|~y)&c;         bo=exact
//   mode3 AFS3 : d=y;                bo=~x&y   (borrow chain cut)
//  APPROX_LSBS=0 or APPROX_MODE=0 -> bit-exact A-B-BIN mod 2^WIDTH, bout=1 iff A<B+BIN.
//  diff/bout change only on the DONE-entry edge; never glitch while out_valid=1.
//  rst mid-RUN or in DONE: abort, return to reset values next cycle, result discarded.
//  rst overrides simultaneous in/out handshakes.
// TESTING
//  T1 W=8 exact: a=0x5A,b=0x3C,bin=0 -> diff=0x1E,bout=0, out_valid 8 cycles after accept.
//  T2 W=8 exact: a=0x00,b=0x01,bin=0 -> diff=0xFF,bout=1; a=0x10,b=0x0F,bin=1 -> 0x00,bout=0.
//  T3 W=8,APPROX_LSBS=4,MODE=1: a=0x00,b=0x01,bin=0 -> diff=0xF1,bout=1.
//  T4 backpressure: hold out_ready=0 for 5 cycles in DONE -> diff/bout/out_valid stable,
//     in_ready=0; in_valid pulses during RUN/DONE are not captured.
//  T5 rst asserted on 3rd RUN cycle -> next cycle in_ready=1,out_valid=0,diff=0; following
//     op a=0x80,b=0x01 -> diff=0x7F,bout=0.
//  T6 random 1000 ops, exact config, random valid/ready stalls vs golden model -> no mismatch.

Source files
------------

// File: rtl/serial_fs_approx.sv
// serial_fs_approx: bit-serial A-B-BIN, LSB first, one full-subtractor cell.
// Ports: clk, rst (sync, high); in_valid/in_ready + a, b, bin; out_valid/out_ready + diff, bout.
module serial_fs_approx #(
  parameter int WIDTH       = 8,
  parameter int APPROX_LSBS = 0,
  parameter int APPROX_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW:0] NAPX = (CW+1)'(APPROX_LSBS);
  localparam logic [1:0] AMODE = 2'(APPROX_MODE);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             borrow;

  logic       x;
  logic       y;
  logic       c;
  logic       d;
  logic       bo;
  logic [1:0] mode;

  assign x = a_sr[0];
  assign y = b_sr[0];
  assign c = borrow;

  // cnt is the bit position being processed
  assign mode = ({1'b0, cnt} < NAPX) ? AMODE : 2'd0;

  always_comb begin
    d  = x ^ y ^ c;
    bo = (~x & y) | (~(x ^ y) & c);
    case (mode)
      2'd1: d = x ^ y;
      2'd2: d = (x | ~y) & c;
      2'd3: begin
        d  = y;
        bo = ~x & y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      cnt       <= '0;
      borrow    <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow   <= bin;
            cnt      <= '0;
            res      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= bo;
          cnt    <= cnt + CW'(1);
          res    <= {d, res[WIDTH-1:1]};
          if (cnt == LAST) begin
            diff      <= {d, res[WIDTH-1:1]};
            bout      <= bo;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_fs_approx.sv
// tb_serial_fs_approx: directed and random checks of serial_fs_approx.
// Four instances share stimulus: exact, and 4 approx LSBs in modes 1..3.
module tb_serial_fs_approx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;

  logic       ir [4];
  logic       ov [4];
  logic [7:0] df [4];
  logic       bo [4];

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    serial_fs_approx #(
      .WIDTH      (8),
      .APPROX_LSBS(k == 0 ? 0 : 4),
      .APPROX_MODE(k)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir[k]),
      .a        (a),
      .b        (b),
      .bin      (bin),
      .out_valid(ov[k]),
      .out_ready(out_ready),
      .diff     (df[k]),
      .bout     (bo[k])
    );
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic c0,
                                       input int md);
    logic       c;
    logic [7:0] d;
    int         m;
    c = c0;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      m = (i < 4) ? md : 0;
      if (m == 3) begin
        d[i] = y[i];
        c    = ~x[i] & y[i];
      end else begin
        if (m == 1) d[i] = x[i] ^ y[i];
        else if (m == 2) d[i] = (x[i] | ~y[i]) & c;
        else d[i] = x[i] ^ y[i] ^ c;
        c = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c);
      end
    end
    return {c, d};
  endfunction

  task automatic send(input logic [7:0] x,
                      input logic [7:0] y,
                      input logic c);
    int n;
    n = 0;
    while (!ir[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("rdy_timeout", 0, 1);
    a        = x;
    b        = y;
    bin      = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!ov[0] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) chk("done_timeout", 0, 1);
  endtask

  task automatic release_out(input int dly);
    repeat (dly) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ov_clr", ov[0], 0);
    chk("ir_set", ir[0], 1);
  endtask

  task automatic check_all(input logic [7:0] x,
                           input logic [7:0] y,
                           input logic c);
    logic [8:0] g;
    g = {1'b0, x} - {1'b0, y} - 9'(c);
    chk("ex_diff", df[0], g[7:0]);
    chk("ex_bout", bo[0], g[8]);
    for (int k = 1; k < 4; k++) begin
      g = model(x, y, c, k);
      chk($sformatf("m%0d_diff", k), df[k], g[7:0]);
      chk($sformatf("m%0d_bout", k), bo[k], g[8]);
    end
  endtask

  int lat;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir", ir[0], 1);
    chk("rst_ov", ov[0], 0);
    chk("rst_diff", df[0], 0);
    chk("rst_bout", bo[0], 0);
    rst = 1'b0;

    // T1
    send(8'h5A, 8'h3C, 1'b0);
    chk("t1_ir_run", ir[0], 0);
    wait_done(lat);
    chk("t1_lat", lat, 8);
    chk("t1_diff", df[0], 8'h1E);
    chk("t1_bout", bo[0], 0);
    check_all(8'h5A, 8'h3C, 1'b0);
    release_out(0);

    // T2
    send(8'h00, 8'h01, 1'b0);
    wait_done(lat);
    chk("t2a_diff", df[0], 8'hFF);
    chk("t2a_bout", bo[0], 1);
    // T3 on the approximate instances
    chk("t3_m1_diff", df[1], 8'hF1);
    chk("t3_m1_bout", bo[1], 1);
    chk("t3_m2_diff", df[2], 8'hFE);
    chk("t3_m2_bout", bo[2], 1);
    chk("t3_m3_diff", df[3], 8'h01);
    chk("t3_m3_bout", bo[3], 0);
    release_out(2);

    send(8'h10, 8'h0F, 1'b1);
    wait_done(lat);
    chk("t2b_diff", df[0], 8'h00);
    chk("t2b_bout", bo[0], 0);
    release_out(1);

    // T4: stray in_valid in RUN and DONE, backpressure in DONE
    send(8'h33, 8'h11, 1'b0);
    a = 8'hFF;
    b = 8'h00;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      chk("t4_ov", ov[0], 1);
      chk("t4_ir", ir[0], 0);
      chk("t4_diff", df[0], 8'h22);
      chk("t4_bout", bo[0], 0);
    end
    in_valid = 1'b0;
    release_out(0);

    // T5: reset on the third RUN cycle
    send(8'h55, 8'h0F, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_ir", ir[0], 1);
    chk("t5_ov", ov[0], 0);
    chk("t5_diff", df[0], 0);
    chk("t5_bout", bo[0], 0);
    send(8'h80, 8'h01, 1'b0);
    wait_done(lat);
    chk("t5_lat", lat, 8);
    chk("t5b_diff", df[0], 8'h7F);
    chk("t5b_bout", bo[0], 0);
    release_out(0);

    // boundary: all ones with borrow-in
    send(8'hFF, 8'hFF, 1'b1);
    wait_done(lat);
    chk("bnd_diff", df[0], 8'hFF);
    chk("bnd_bout", bo[0], 1);
    check_all(8'hFF, 8'hFF, 1'b1);
    release_out(0);

    // T6: random ops with stalls
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] x;
      logic [7:0] y;
      logic       c;
      x = 8'($urandom);
      y = 8'($urandom);
      c = 1'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(x, y, c);
      wait_done(lat);
      check_all(x, y, c);
      release_out($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
